// File: rtl/id_decode_pipe_if.sv
// Handshake bundle for the MIPS-I decode stage.
//   in_*  : fetch side (valid/ready, raw instruction, pc+4)
//   out_* : execute side (valid/ready, decoded fields, immediate, targets, pc+4)
// Modports:
//   master : environment driving instructions in and accepting decoded ones out
//   slave  : the decode stage itself
interface id_decode_pipe_if #(
  parameter int unsigned DATA_W = 32,
  parameter int unsigned PC_W   = 32
);
  logic              in_valid;
  logic              in_ready;
  logic [31:0]       in_instr;
  logic [PC_W-1:0]   in_pc4;

  logic              out_valid;
  logic              out_ready;
  logic [5:0]        out_opcode;
  logic [5:0]        out_funct;
  logic [4:0]        out_rs;
  logic [4:0]        out_rt;
  logic [4:0]        out_rd;
  logic [4:0]        out_shamt;
  logic [DATA_W-1:0] out_imm;
  logic [PC_W-1:0]   out_br_target;
  logic [PC_W-1:0]   out_jmp_target;
  logic [PC_W-1:0]   out_pc4;

  modport master (
    output in_valid, in_instr, in_pc4, out_ready,
    input  in_ready, out_valid, out_opcode, out_funct, out_rs, out_rt, out_rd,
           out_shamt, out_imm, out_br_target, out_jmp_target, out_pc4
  );

  modport slave (
    input  in_valid, in_instr, in_pc4, out_ready,
    output in_ready, out_valid, out_opcode, out_funct, out_rs, out_rt, out_rd,
           out_shamt, out_imm, out_br_target, out_jmp_target, out_pc4
  );
endinterface

// File: rtl/id_decode_pipe.sv
// Registered MIPS-I instruction-decode stage with a 2-entry skid buffer.
// Ports:
//   clk   : clock, rising edge
//   rst_n : asynchronous active-low reset
//   flush : drop all buffered and incoming instructions
//   bus   : id_decode_pipe_if.slave (fetch-side input handshake, execute-side
//           output handshake with decoded fields, immediate, branch/jump targets)
// Decode is combinational on the input side; every output comes from the head
// register, so there is no input-to-output combinational path.
module id_decode_pipe #(
  parameter int unsigned DATA_W   = 32,
  parameter int unsigned PC_W     = 32,
  parameter bit          ZEXT_LOG = 1'b1
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               flush,
  id_decode_pipe_if.slave    bus
);

  typedef enum logic [1:0] {S_EMPTY, S_ONE, S_FULL} state_t;

  typedef struct packed {
    logic [5:0]        opcode;
    logic [5:0]        funct;
    logic [4:0]        rs;
    logic [4:0]        rt;
    logic [4:0]        rd;
    logic [4:0]        shamt;
    logic [DATA_W-1:0] imm;
    logic [PC_W-1:0]   br;
    logic [PC_W-1:0]   jmp;
    logic [PC_W-1:0]   pc4;
  } dec_t;

  state_t state_q, state_d;
  logic   in_ready_q, in_ready_d;
  dec_t   head_q, head_d;
  dec_t   tail_q, tail_d;
  dec_t   dec_in;
  logic   in_xfer, out_xfer;
  logic [15:0] imm16;

  // Field split and immediate extension of the incoming instruction.
  always_comb begin
    imm16         = bus.in_instr[15:0];
    dec_in.opcode = bus.in_instr[31:26];
    dec_in.rs     = bus.in_instr[25:21];
    dec_in.rt     = bus.in_instr[20:16];
    dec_in.rd     = bus.in_instr[15:11];
    dec_in.shamt  = bus.in_instr[10:6];
    dec_in.funct  = bus.in_instr[5:0];
    dec_in.pc4    = bus.in_pc4;
    if (dec_in.opcode == 6'h0F)
      dec_in.imm = DATA_W'($signed({imm16, 16'h0000}));
    else if (ZEXT_LOG && (dec_in.opcode == 6'h0C || dec_in.opcode == 6'h0D ||
                          dec_in.opcode == 6'h0E))
      dec_in.imm = DATA_W'(imm16);
    else
      dec_in.imm = DATA_W'($signed(imm16));
    // Branch target always uses the sign-extended offset and wraps naturally.
    dec_in.br      = bus.in_pc4 + (PC_W'($signed(imm16)) << 2);
    // Upper PC bits kept, low 28 replaced; written this way so PC_W == 28 works.
    dec_in.jmp       = bus.in_pc4;
    dec_in.jmp[27:0] = {bus.in_instr[25:0], 2'b00};
  end

  assign in_xfer  = bus.in_valid & in_ready_q;
  assign out_xfer = (state_q != S_EMPTY) & bus.out_ready;

  always_comb begin
    state_d = state_q;
    head_d  = head_q;
    tail_d  = tail_q;
    unique case (state_q)
      S_EMPTY: begin
        if (in_xfer) begin
          head_d  = dec_in;
          state_d = S_ONE;
        end
      end
      S_ONE: begin
        if (in_xfer && out_xfer) begin
          head_d = dec_in;
        end else if (in_xfer) begin
          tail_d  = dec_in;
          state_d = S_FULL;
        end else if (out_xfer) begin
          state_d = S_EMPTY;
        end
      end
      S_FULL: begin
        // in_ready is low here, so only the consume side can move.
        if (out_xfer) begin
          head_d  = tail_q;
          state_d = S_ONE;
        end
      end
      default: state_d = S_EMPTY;
    endcase
    if (flush) state_d = S_EMPTY;
    in_ready_d = (state_d != S_FULL);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= S_EMPTY;
      in_ready_q <= 1'b1;
      head_q     <= '0;
      tail_q     <= '0;
    end else begin
      state_q    <= state_d;
      in_ready_q <= in_ready_d;
      head_q     <= head_d;
      tail_q     <= tail_d;
    end
  end

  assign bus.in_ready       = in_ready_q;
  assign bus.out_valid      = (state_q != S_EMPTY);
  assign bus.out_opcode     = head_q.opcode;
  assign bus.out_funct      = head_q.funct;
  assign bus.out_rs         = head_q.rs;
  assign bus.out_rt         = head_q.rt;
  assign bus.out_rd         = head_q.rd;
  assign bus.out_shamt      = head_q.shamt;
  assign bus.out_imm        = head_q.imm;
  assign bus.out_br_target  = head_q.br;
  assign bus.out_jmp_target = head_q.jmp;
  assign bus.out_pc4        = head_q.pc4;

endmodule

// File: tb/tb_id_decode_pipe.sv
// Testbench for id_decode_pipe: two instances (ZEXT_LOG=1 and ZEXT_LOG=0) fed
// identical stimulus, checked against a queue-based reference model.
module tb_id_decode_pipe;

  logic clk   = 1'b0;
  logic rst_n = 1'b0;
  logic flush = 1'b0;

  always #5 clk = ~clk;

  id_decode_pipe_if #(.DATA_W(32), .PC_W(32)) bus  ();
  id_decode_pipe_if #(.DATA_W(32), .PC_W(32)) bus0 ();

  id_decode_pipe #(.DATA_W(32), .PC_W(32), .ZEXT_LOG(1'b1)) dut (
    .clk(clk), .rst_n(rst_n), .flush(flush), .bus(bus)
  );

  id_decode_pipe #(.DATA_W(32), .PC_W(32), .ZEXT_LOG(1'b0)) dut0 (
    .clk(clk), .rst_n(rst_n), .flush(flush), .bus(bus0)
  );

  assign bus0.in_valid  = bus.in_valid;
  assign bus0.in_instr  = bus.in_instr;
  assign bus0.in_pc4    = bus.in_pc4;
  assign bus0.out_ready = bus.out_ready;

  typedef struct {
    logic [31:0] instr;
    logic [31:0] pc4;
    logic [31:0] imm1;
    logic [31:0] imm0;
    logic [31:0] br;
    logic [31:0] jmp;
  } rec_t;

  rec_t q[$];
  int unsigned tests = 0;
  int unsigned fails = 0;

  function automatic rec_t model(logic [31:0] instr, logic [31:0] pc4);
    rec_t r;
    int unsigned op = instr >> 26;
    int unsigned u  = instr & 32'hFFFF;
    int          s  = (u >= 32768) ? int'(u) - 65536 : int'(u);
    r.instr = instr;
    r.pc4   = pc4;
    r.imm0  = (op == 15) ? u * 65536 : 32'(s);
    r.imm1  = (op >= 12 && op <= 14) ? u : r.imm0;
    r.br    = pc4 + 32'(s * 4);
    r.jmp   = (pc4 & 32'hF0000000) | ((instr & 32'h03FFFFFF) * 4);
    return r;
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic check_all();
    rec_t r;
    chk("out_valid",  32'(bus.out_valid),  32'(q.size() != 0));
    chk("in_ready",   32'(bus.in_ready),   32'(q.size() < 2));
    chk("out_valid0", 32'(bus0.out_valid), 32'(q.size() != 0));
    chk("in_ready0",  32'(bus0.in_ready),  32'(q.size() < 2));
    if (q.size() != 0) begin
      r = q[0];
      chk("opcode", 32'(bus.out_opcode), (r.instr >> 26) & 32'h3F);
      chk("rs",     32'(bus.out_rs),     (r.instr >> 21) & 32'h1F);
      chk("rt",     32'(bus.out_rt),     (r.instr >> 16) & 32'h1F);
      chk("rd",     32'(bus.out_rd),     (r.instr >> 11) & 32'h1F);
      chk("shamt",  32'(bus.out_shamt),  (r.instr >> 6) & 32'h1F);
      chk("funct",  32'(bus.out_funct),  r.instr & 32'h3F);
      chk("imm",    bus.out_imm,         r.imm1);
      chk("imm_z0", bus0.out_imm,        r.imm0);
      chk("br",     bus.out_br_target,   r.br);
      chk("jmp",    bus.out_jmp_target,  r.jmp);
      chk("pc4",    bus.out_pc4,         r.pc4);
    end
  endtask

  task automatic drive(input logic v, input logic [31:0] instr, input logic [31:0] pc4,
                       input logic ordy, input logic fl);
    bus.in_valid  = v;
    bus.in_instr  = instr;
    bus.in_pc4    = pc4;
    bus.out_ready = ordy;
    flush         = fl;
  endtask

  // One clock: predict acceptance from the model, advance, then check.
  task automatic cycle();
    bit ia, oa;
    rec_t r;
    ia = bus.in_valid && q.size() < 2;
    oa = bus.out_ready && q.size() > 0;
    r  = model(bus.in_instr, bus.in_pc4);
    @(posedge clk);
    if (flush) q.delete();
    else begin
      if (oa) void'(q.pop_front());
      if (ia) q.push_back(r);
    end
    @(negedge clk);
    check_all();
  endtask

  initial begin
    logic [31:0] ops [9];
    ops = '{32'h00, 32'h08, 32'h0C, 32'h0D, 32'h0E, 32'h0F, 32'h02, 32'h04, 32'h23};
    drive(1'b0, '0, '0, 1'b0, 1'b0);

    // Reset state
    @(negedge clk); @(negedge clk);
    check_all();
    chk("rst_imm", bus.out_imm, 32'h0);
    chk("rst_br",  bus.out_br_target, 32'h0);
    chk("rst_pc4", bus.out_pc4, 32'h0);
    rst_n = 1'b1;

    // ADDI
    drive(1'b1, 32'h2108FFFC, 32'h00400004, 1'b1, 1'b0); cycle();
    chk("t1_imm", bus.out_imm, 32'hFFFFFFFC);
    chk("t1_br",  bus.out_br_target, 32'h003FFFF4);
    chk("t1_op",  32'(bus.out_opcode), 32'h08);

    // LUI then ORI (head replaced while both sides transfer)
    drive(1'b1, 32'h3C01ABCD, 32'h00400008, 1'b1, 1'b0); cycle();
    chk("t2_lui", bus.out_imm, 32'hABCD0000);
    drive(1'b1, 32'h3421ABCD, 32'h0040000C, 1'b1, 1'b0); cycle();
    chk("t2_ori",  bus.out_imm, 32'h0000ABCD);
    chk("t2_ori0", bus0.out_imm, 32'hFFFFABCD);

    // Jump and wrapping branch
    drive(1'b1, 32'h08100010, 32'hA0000008, 1'b1, 1'b0); cycle();
    chk("t3_jmp", bus.out_jmp_target, 32'hA0400040);
    drive(1'b1, 32'h1000FFFF, 32'h00000000, 1'b1, 1'b0); cycle();
    chk("t3_br",  bus.out_br_target, 32'hFFFFFFFC);
    drive(1'b0, '0, '0, 1'b1, 1'b0); cycle();

    // Back-pressure: A, B accepted, C stalled, then drained in order
    drive(1'b1, 32'h8C410004, 32'h00001004, 1'b0, 1'b0); cycle();
    drive(1'b1, 32'hAC620008, 32'h00001008, 1'b0, 1'b0); cycle();
    drive(1'b1, 32'h00432020, 32'h0000100C, 1'b0, 1'b0); cycle(); cycle();
    drive(1'b1, 32'h00432020, 32'h0000100C, 1'b1, 1'b0); cycle(); cycle();
    drive(1'b0, '0, '0, 1'b1, 1'b0); cycle(); cycle();

    // Flush while full with a concurrent input
    drive(1'b1, 32'h24050001, 32'h00002004, 1'b0, 1'b0); cycle();
    drive(1'b1, 32'h24060002, 32'h00002008, 1'b0, 1'b0); cycle();
    drive(1'b1, 32'h24070003, 32'h0000200C, 1'b0, 1'b1); cycle();
    drive(1'b0, '0, '0, 1'b1, 1'b0); cycle(); cycle();

    // Asynchronous reset while one entry is held
    drive(1'b1, 32'h30E7FFFF, 32'h00003004, 1'b0, 1'b0); cycle();
    drive(1'b0, '0, '0, 1'b0, 1'b0);
    #2 rst_n = 1'b0;
    #1;
    chk("arst_valid", 32'(bus.out_valid), 32'h0);
    chk("arst_ready", 32'(bus.in_ready), 32'h1);
    chk("arst_imm",   bus.out_imm, 32'h0);
    q.delete();
    @(negedge clk);
    rst_n = 1'b1;
    drive(1'b1, 32'h3908F0F0, 32'h00004004, 1'b1, 1'b0); cycle();
    chk("arst_first", bus.out_pc4, 32'h00004004);
    drive(1'b0, '0, '0, 1'b1, 1'b0); cycle();

    // Randomized traffic
    for (int i = 0; i < 400; i++) begin
      logic [31:0] instr;
      instr = (ops[$urandom_range(8)] << 26) | ($urandom & 32'h03FFFFFF);
      drive(1'($urandom_range(1)), instr, $urandom, 1'($urandom_range(3) != 0),
            1'($urandom_range(15) == 0));
      cycle();
    end
    drive(1'b0, '0, '0, 1'b1, 1'b0); cycle(); cycle();

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
